// File: rtl/game_pkg.sv
// Shared types and default timing for the artillery game: turn phases,
// player IDs and frame-count constants.
package game_pkg;

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_AIM    = 3'd1,
    S_FLIGHT = 3'd2,
    S_SETTLE = 3'd3,
    S_SWITCH = 3'd4,
    S_OVER   = 3'd5
  } phase_e;

  typedef logic player_id_t;

  localparam int DEF_TURN_FRAMES   = 600;
  localparam int DEF_FLIGHT_MAX    = 240;
  localparam int DEF_SETTLE_FRAMES = 30;
  localparam int TIMER_W           = 10;

endpackage

// File: rtl/frame_timer.sv
// Loadable frame counter: counts up or down (saturating) and flags when the
// count equals a caller-supplied terminal value.
module frame_timer #(
  parameter int             W         = 10,
  parameter logic [W-1:0]   RESET_VAL = '0
) (
  input  logic         frame_clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_up,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge frame_clk or posedge reset) begin
    if (reset) begin
      r_count <= RESET_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      if (i_up) begin
        if (r_count != '1) r_count <= r_count + W'(1);
      end else begin
        if (r_count != '0) r_count <= r_count - W'(1);
      end
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == i_term);

endmodule

// File: rtl/turn_scheduler.sv
// Two-player turn sequencer: routes the keyboard to the active player, runs
// the aim countdown, flight/settle waits, turn handover and end-of-game.
module turn_scheduler
  import game_pkg::*;
#(
  parameter int TURN_FRAMES   = DEF_TURN_FRAMES,
  parameter int FLIGHT_MAX    = DEF_FLIGHT_MAX,
  parameter int SETTLE_FRAMES = DEF_SETTLE_FRAMES
) (
  input  logic       frame_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] keycode,
  input  logic [7:0] shoot_code0,
  input  logic [7:0] shoot_code1,
  input  logic       bomb_busy0,
  input  logic       bomb_busy1,
  input  logic       dead0,
  input  logic       dead1,
  output logic [7:0] keycode_p0,
  output logic [7:0] keycode_p1,
  output logic       active_id,
  output logic [9:0] frames_left,
  output logic [2:0] phase,
  output logic [7:0] turn_count,
  output logic       game_over,
  output logic       draw,
  output logic       winner
);

  localparam logic [TIMER_W-1:0] TURN_LOAD = TIMER_W'(TURN_FRAMES);

  phase_e     r_state, w_state_next;
  player_id_t r_active_id, w_active_next;
  logic [7:0] r_turn_count, w_turn_next;
  logic       r_game_over, w_game_over_next;
  logic       r_draw, w_draw_next;
  logic       r_winner, w_winner_next;

  logic               w_shot, w_busy, w_dead;
  logic               w_aim_load, w_aim_en, w_aim_zero;
  logic [TIMER_W-1:0] w_aim_count;
  logic               w_fs_load, w_fs_en, w_fs_tc;
  logic [TIMER_W-1:0] w_fs_count, w_fs_term;

  assign w_shot = (keycode == (r_active_id ? shoot_code1 : shoot_code0));
  assign w_busy = r_active_id ? bomb_busy1 : bomb_busy0;
  assign w_dead = dead0 | dead1;

  frame_timer #(.W(TIMER_W), .RESET_VAL(TURN_LOAD)) u_aim_timer (
    .frame_clk  (frame_clk),
    .reset      (reset),
    .i_load     (w_aim_load),
    .i_load_val (TURN_LOAD),
    .i_en       (w_aim_en),
    .i_up       (1'b0),
    .i_term     ('0),
    .o_count    (w_aim_count),
    .o_tc       (w_aim_zero)
  );

  // The counter holds (frames spent in the state - 1), so matching N-1 ends a
  // dwell of exactly N frames.
  assign w_fs_term = (r_state == S_FLIGHT) ? TIMER_W'(FLIGHT_MAX - 1)
                                           : TIMER_W'(SETTLE_FRAMES - 1);
  assign w_fs_load = (w_state_next != r_state);
  assign w_fs_en   = (r_state == S_FLIGHT) || (r_state == S_SETTLE);

  frame_timer #(.W(TIMER_W), .RESET_VAL('0)) u_fs_timer (
    .frame_clk  (frame_clk),
    .reset      (reset),
    .i_load     (w_fs_load),
    .i_load_val ('0),
    .i_en       (w_fs_en),
    .i_up       (1'b1),
    .i_term     (w_fs_term),
    .o_count    (w_fs_count),
    .o_tc       (w_fs_tc)
  );

  always_ff @(posedge frame_clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_START;
      r_active_id  <= 1'b0;
      r_turn_count <= '0;
      r_game_over  <= 1'b0;
      r_draw       <= 1'b0;
      r_winner     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_active_id  <= w_active_next;
      r_turn_count <= w_turn_next;
      r_game_over  <= w_game_over_next;
      r_draw       <= w_draw_next;
      r_winner     <= w_winner_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_active_next    = r_active_id;
    w_turn_next      = r_turn_count;
    w_game_over_next = r_game_over;
    w_draw_next      = r_draw;
    w_winner_next    = r_winner;
    w_aim_load       = 1'b0;
    w_aim_en         = 1'b0;

    // Death outranks every in-game transition.
    if (w_dead && (r_state inside {S_AIM, S_FLIGHT, S_SETTLE, S_SWITCH})) begin
      w_state_next     = S_OVER;
      w_game_over_next = 1'b1;
      w_draw_next      = dead0 & dead1;
      w_winner_next    = dead0 & ~dead1;
    end else begin
      case (r_state)
        S_START: begin
          if (start) begin
            w_state_next  = S_AIM;
            w_active_next = 1'b0;
            w_turn_next   = '0;
            w_aim_load    = 1'b1;
          end
        end
        S_AIM: begin
          if (w_shot)          w_state_next = S_FLIGHT;
          else if (w_aim_zero) w_state_next = S_SWITCH;
          else                 w_aim_en     = 1'b1;
        end
        S_FLIGHT: begin
          if (w_fs_tc || ((w_fs_count != '0) && !w_busy)) w_state_next = S_SETTLE;
        end
        S_SETTLE: begin
          if (w_fs_tc) w_state_next = S_SWITCH;
        end
        S_SWITCH: begin
          w_state_next  = S_AIM;
          w_active_next = ~r_active_id;
          w_aim_load    = 1'b1;
          if (r_turn_count != 8'hFF) w_turn_next = r_turn_count + 8'd1;
        end
        S_OVER: begin
          if (start) begin
            w_state_next     = S_START;
            w_game_over_next = 1'b0;
            w_draw_next      = 1'b0;
            w_winner_next    = 1'b0;
          end
        end
        default: w_state_next = S_START;
      endcase
    end
  end

  assign keycode_p0  = ((r_state == S_AIM) && (r_active_id == 1'b0)) ? keycode : 8'h00;
  assign keycode_p1  = ((r_state == S_AIM) && (r_active_id == 1'b1)) ? keycode : 8'h00;
  assign active_id   = r_active_id;
  assign frames_left = w_aim_count;
  assign phase       = r_state;
  assign turn_count  = r_turn_count;
  assign game_over   = r_game_over;
  assign draw        = r_draw;
  assign winner      = r_winner;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler: stimulus queues expected outputs per
// frame, a negedge monitor pops and compares them.
module tb_turn_scheduler;

  localparam logic [7:0] SC0 = 8'h20;
  localparam logic [7:0] SC1 = 8'h21;

  localparam int SEL_PHASE = 0, SEL_ACT = 1, SEL_FRAMES = 2, SEL_TURN = 3;
  localparam int SEL_GO = 4, SEL_DRAW = 5, SEL_WIN = 6, SEL_KP0 = 7, SEL_KP1 = 8;

  logic       frame_clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] keycode = 8'h55;
  logic [7:0] shoot_code0 = SC0;
  logic [7:0] shoot_code1 = SC1;
  logic       bomb_busy0 = 1'b0, bomb_busy1 = 1'b0;
  logic       dead0 = 1'b0, dead1 = 1'b0;
  logic [7:0] keycode_p0, keycode_p1;
  logic       active_id;
  logic [9:0] frames_left;
  logic [2:0] phase;
  logic [7:0] turn_count;
  logic       game_over, draw, winner;

  turn_scheduler dut (
    .frame_clk   (frame_clk),
    .reset       (reset),
    .start       (start),
    .keycode     (keycode),
    .shoot_code0 (shoot_code0),
    .shoot_code1 (shoot_code1),
    .bomb_busy0  (bomb_busy0),
    .bomb_busy1  (bomb_busy1),
    .dead0       (dead0),
    .dead1       (dead1),
    .keycode_p0  (keycode_p0),
    .keycode_p1  (keycode_p1),
    .active_id   (active_id),
    .frames_left (frames_left),
    .phase       (phase),
    .turn_count  (turn_count),
    .game_over   (game_over),
    .draw        (draw),
    .winner      (winner)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {
    int         cyc;
    int         sel;
    logic [9:0] val;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge frame_clk) cyc <= cyc + 1;

  function automatic logic [9:0] actual(input int sel);
    case (sel)
      SEL_PHASE:  return 10'(phase);
      SEL_ACT:    return 10'(active_id);
      SEL_FRAMES: return frames_left;
      SEL_TURN:   return 10'(turn_count);
      SEL_GO:     return 10'(game_over);
      SEL_DRAW:   return 10'(draw);
      SEL_WIN:    return 10'(winner);
      SEL_KP0:    return 10'(keycode_p0);
      SEL_KP1:    return 10'(keycode_p1);
      default:    return '0;
    endcase
  endfunction

  // Monitor: every frame, compare all expectations queued for this frame.
  always @(negedge frame_clk) begin
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      n_tests++;
      if (actual(mon_e.sel) !== mon_e.val) begin
        n_fail++;
        $display("FAIL %s frame=%0d actual=%0d expected=%0d",
                 mon_e.name, cyc, actual(mon_e.sel), mon_e.val);
      end else begin
        $display("[TB] check %s frame=%0d value=%0d", mon_e.name, cyc, mon_e.val);
      end
    end
  end

  task automatic chk(input int sel, input logic [9:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = sel;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge frame_clk);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at frame %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    step(2);
    n_tests++;
    if (phase !== 3'd0) begin
      n_fail++;
      $display("FAIL direct_rst_phase frame=%0d actual=%0d expected=0", cyc, phase);
    end else begin
      $display("[TB] check direct_rst_phase frame=%0d value=0", cyc);
    end
    chk(SEL_PHASE, 0, "rst_phase");
    chk(SEL_FRAMES, 600, "rst_frames");
    chk(SEL_ACT, 0, "rst_active");
    chk(SEL_TURN, 0, "rst_turn");
    chk(SEL_GO, 0, "rst_game_over");
    chk(SEL_KP0, 0, "rst_kp0");
    reset = 1'b0;
    step(1);
    chk(SEL_PHASE, 0, "idle_start");

    // Start, then player 0 shoots
    start = 1'b1;
    step(1);
    start = 1'b0;
    keycode = 8'h41;
    n_tests++;
    if (frames_left !== 10'd600) begin
      n_fail++;
      $display("FAIL direct_start_frames frame=%0d actual=%0d expected=600", cyc, frames_left);
    end else begin
      $display("[TB] check direct_start_frames frame=%0d value=600", cyc);
    end
    chk(SEL_PHASE, 1, "start_aim");
    chk(SEL_ACT, 0, "start_active");
    chk(SEL_FRAMES, 600, "start_frames");
    chk(SEL_TURN, 0, "start_turn");
    chk(SEL_KP0, 10'h41, "aim_kp0_fwd");
    chk(SEL_KP1, 0, "aim_kp1_blocked");
    step(1);
    chk(SEL_FRAMES, 599, "aim_decrement");
    keycode = SC0;
    chk(SEL_KP0, 10'(SC0), "shoot_fwd_kp0");
    chk(SEL_KP1, 0, "shoot_kp1_blocked");
    step(1);
    bomb_busy0 = 1'b1;
    chk(SEL_PHASE, 2, "flight_entered");
    chk(SEL_KP0, 0, "flight_input_cut");
    chk(SEL_FRAMES, 599, "flight_frames_held");
    step(1);
    keycode = 8'h00;
    step(48);
    chk(SEL_PHASE, 2, "flight_busy50");
    bomb_busy0 = 1'b0;
    step(1);
    chk(SEL_PHASE, 3, "settle_entered");
    step(29);
    chk(SEL_PHASE, 3, "settle_30th");
    step(1);
    chk(SEL_PHASE, 4, "switch_entered");
    chk(SEL_TURN, 0, "switch_turn_old");
    step(1);
    keycode = SC0;
    n_tests++;
    if (active_id !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_p1_active frame=%0d actual=%0d expected=1", cyc, active_id);
    end else begin
      $display("[TB] check direct_p1_active frame=%0d value=1", cyc);
    end
    chk(SEL_PHASE, 1, "p1_aim");
    chk(SEL_ACT, 1, "p1_active");
    chk(SEL_TURN, 1, "p1_turn1");
    chk(SEL_FRAMES, 600, "p1_frames");
    chk(SEL_KP1, 10'(SC0), "p1_kp1_fwd");
    chk(SEL_KP0, 0, "p1_kp0_blocked");

    // Player 1 lets the timer run out
    step(1);
    keycode = 8'h00;
    chk(SEL_PHASE, 1, "p1_other_key_no_shot");
    step(599);
    chk(SEL_FRAMES, 0, "timeout_zero");
    chk(SEL_PHASE, 1, "timeout_last_aim");
    step(1);
    chk(SEL_PHASE, 4, "timeout_switch");
    step(1);
    chk(SEL_PHASE, 1, "p0_aim_again");
    chk(SEL_ACT, 0, "p0_active_again");
    chk(SEL_TURN, 2, "turn2");
    chk(SEL_FRAMES, 600, "frames_reload");

    // Shot on the expiry frame, then bomb stuck busy
    step(600);
    chk(SEL_FRAMES, 0, "expiry_frame");
    keycode = SC0;
    chk(SEL_KP0, 10'(SC0), "expiry_shot_fwd");
    step(1);
    bomb_busy0 = 1'b1;
    chk(SEL_PHASE, 2, "shot_beats_expiry");
    step(1);
    keycode = 8'h00;
    step(238);
    chk(SEL_PHASE, 2, "stuck_flight_240");
    step(1);
    chk(SEL_PHASE, 3, "stuck_timeout_settle");
    bomb_busy0 = 1'b0;
    step(29);
    step(1);
    chk(SEL_PHASE, 4, "switch_after_timeout");
    step(1);
    keycode = SC1;
    chk(SEL_ACT, 1, "p1_turn3_active");
    chk(SEL_TURN, 3, "turn3");
    chk(SEL_KP1, 10'(SC1), "p1_shoot_fwd");
    chk(SEL_KP0, 0, "p1_shoot_kp0_blocked");
    step(1);
    bomb_busy1 = 1'b1;
    step(1);
    chk(SEL_PHASE, 2, "p1_flight");
    chk(SEL_ACT, 1, "p1_flight_active");
    step(1);

    // Reset during flight
    reset = 1'b1;
    chk(SEL_PHASE, 0, "midrst_phase");
    chk(SEL_ACT, 0, "midrst_active");
    chk(SEL_FRAMES, 600, "midrst_frames");
    chk(SEL_TURN, 0, "midrst_turn");
    chk(SEL_KP1, 0, "midrst_kp1");
    step(2);
    reset = 1'b0;
    bomb_busy1 = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    keycode = SC0;
    chk(SEL_PHASE, 1, "restart_aim");
    step(1);
    keycode = 8'h00;
    step(1);
    chk(SEL_PHASE, 2, "min_flight_frame2");
    step(1);
    chk(SEL_PHASE, 3, "min_flight_settle");

    // Deaths and results
    dead1 = 1'b1;
    step(1);
    dead1 = 1'b0;
    chk(SEL_PHASE, 5, "dead1_over");
    chk(SEL_GO, 1, "dead1_game_over");
    chk(SEL_WIN, 0, "dead1_winner0");
    chk(SEL_DRAW, 0, "dead1_no_draw");
    step(1);
    chk(SEL_PHASE, 5, "over_holds");
    start = 1'b1;
    step(1);
    chk(SEL_PHASE, 0, "over_to_start");
    chk(SEL_GO, 0, "start_clears_go");
    step(1);
    start = 1'b0;
    dead0 = 1'b1;
    dead1 = 1'b1;
    chk(SEL_PHASE, 1, "game2_aim");
    step(1);
    dead0 = 1'b0;
    dead1 = 1'b0;
    chk(SEL_PHASE, 5, "both_dead_over");
    chk(SEL_DRAW, 1, "both_dead_draw");
    chk(SEL_WIN, 0, "both_dead_winner0");
    chk(SEL_GO, 1, "both_dead_go");
    start = 1'b1;
    step(1);
    chk(SEL_DRAW, 0, "start_clears_draw");
    step(1);
    start = 1'b0;
    dead0 = 1'b1;
    step(1);
    dead0 = 1'b0;
    n_tests++;
    if (winner !== 1'b1) begin
      n_fail++;
      $display("FAIL direct_dead0_winner frame=%0d actual=%0d expected=1", cyc, winner);
    end else begin
      $display("[TB] check direct_dead0_winner frame=%0d value=1", cyc);
    end
    chk(SEL_PHASE, 5, "dead0_over");
    chk(SEL_WIN, 1, "dead0_winner1");
    chk(SEL_DRAW, 0, "dead0_no_draw");

    @(negedge frame_clk);
    #1;
    while (q.size() != 0) begin
      mon_e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s never compared (expected=%0d)", mon_e.name, mon_e.val);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
